// File: rtl/io_ccff_loader_pkg.sv
// Shared types and constants for the IO-tile configuration-chain loader.
package io_ccff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISO_PRE  = 2'd1,
      ST_SHIFT    = 2'd2,
      ST_ISO_POST = 2'd3
   } state_e;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Width of a counter that must hold every value 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/io_ccff_loader_if.sv
// Bitstream word stream from the loader into the chain sequencer.
interface io_ccff_loader_if #(
   parameter int WORD_W = 8
) ();
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input  cfg_ready);
   modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/io_ccff_loader_crc16.sv
// Serial CRC-16-CCITT accumulator, MSB-first update, one bit per enabled cycle.
// Only instantiated when IO_CCFF_READBACK_EN is defined.
// crc_o already includes the bit presented this cycle, so the owner can
// capture the final value on the same edge that folds in the last bit.
module io_ccff_crc16
   import io_ccff_pkg::*;
(
   input  logic        prog_clk,
   input  logic        pReset_n,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        bit_i,
   output logic [15:0] crc_o
);
   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic        fb;

   // One polynomial step when enabled; a clear restarts from the init value.
   always_comb begin
      fb    = crc_q[15] ^ bit_i;
      crc_o = crc_q;
      if (en_i) begin
         crc_o = fb ? ({crc_q[14:0], 1'b0} ^ CRC_POLY) : {crc_q[14:0], 1'b0};
      end
      crc_d = clr_i ? CRC_INIT : crc_o;
   end

   // Accumulator register.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) crc_q <= CRC_INIT;
      else           crc_q <= crc_d;
   end
endmodule

// File: rtl/io_ccff_loader.sv
// Programming sequencer for one IO-tile ccff chain: takes bitstream words,
// shifts them LSB-first onto ccff_head through a chain clock-enable, and keeps
// the IO tiles isolated for the whole programming window.
// Optional readback CRC of the old chain contents: define IO_CCFF_READBACK_EN.
//
// state       | meaning
// ------------|-------------------------------------------------------------
// ST_IDLE     | waiting for start; IO_ISOL_N=1 once a pass has completed
// ST_ISO_PRE  | isolated, ISO_HOLD settle cycles before the first shift
// ST_SHIFT    | refill word buffer / shift one bit per cycle until CHAIN_LEN
// ST_ISO_POST | isolated, ISO_HOLD cycles after the last shift, then done
module io_ccff_loader
   import io_ccff_pkg::*;
#(
   parameter int CHAIN_LEN = 4,
   parameter int WORD_W    = 8,
   parameter int ISO_HOLD  = 4
) (
   input  logic            prog_clk,
   input  logic            pReset_n,
   input  logic            start,
   io_ccff_loader_if.slave cfg,
   input  logic            ccff_tail,
   output logic            ccff_head,
   output logic            chain_clk_en,
   output logic            IO_ISOL_N,
   output logic            busy,
   output logic            done,
   output logic [15:0]     rb_crc
);
   localparam int CNT_W  = cnt_w(CHAIN_LEN);
   localparam int BCNT_W = cnt_w(WORD_W);
   localparam int HOLD_W = cnt_w(ISO_HOLD);

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN);
   localparam logic [BCNT_W-1:0] WORD_BITS = BCNT_W'(WORD_W);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ISO_HOLD - 1);

   state_e              state_q,  state_d;
   logic [HOLD_W-1:0]   hold_q,   hold_d;
   logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
   logic [WORD_W-1:0]   buf_q,    buf_d;
   logic [BCNT_W-1:0]   bufcnt_q, bufcnt_d;
   logic                head_q,   head_d;
   logic                en_q,     en_d;
   logic                isol_n_q, isol_n_d;
   logic                ready_q,  ready_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;
   logic                prog_q,   prog_d;

   // Next-state and registered-output decode; outputs are derived from the
   // next state so they line up with the state they describe.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      bitcnt_d = bitcnt_q;
      buf_d    = buf_q;
      bufcnt_d = bufcnt_q;
      head_d   = head_q;
      en_d     = 1'b0;
      done_d   = 1'b0;
      prog_d   = prog_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_ISO_PRE;
               hold_d   = HOLD_LOAD;
               bitcnt_d = '0;
               buf_d    = '0;
               bufcnt_d = '0;
            end
         end
         ST_ISO_PRE: begin
            if (hold_q == '0) state_d = ST_SHIFT;
            else              hold_d  = hold_q - 1'b1;
         end
         ST_SHIFT: begin
            if (bitcnt_q == LAST_BIT) begin
               // unused tail of the final word is dropped here
               state_d  = ST_ISO_POST;
               hold_d   = HOLD_LOAD;
               buf_d    = '0;
               bufcnt_d = '0;
            end else if (cfg.cfg_valid && ready_q) begin
               buf_d    = cfg.cfg_data;
               bufcnt_d = WORD_BITS;
            end else if (bufcnt_q != '0) begin
               head_d   = buf_q[0];
               en_d     = 1'b1;
               buf_d    = buf_q >> 1;
               bufcnt_d = bufcnt_q - 1'b1;
               bitcnt_d = bitcnt_q + 1'b1;
            end
         end
         ST_ISO_POST: begin
            if (hold_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               prog_d  = 1'b1;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d  = (state_d == ST_SHIFT) && (bufcnt_d == '0) && (bitcnt_d != LAST_BIT);
      isol_n_d = (state_d == ST_IDLE) && prog_d;
      busy_d   = (state_d != ST_IDLE);
   end

   // State and output registers; reset drops everything back to isolated IDLE.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state_q  <= ST_IDLE;
         hold_q   <= '0;
         bitcnt_q <= '0;
         buf_q    <= '0;
         bufcnt_q <= '0;
         head_q   <= 1'b0;
         en_q     <= 1'b0;
         isol_n_q <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         prog_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         bitcnt_q <= bitcnt_d;
         buf_q    <= buf_d;
         bufcnt_q <= bufcnt_d;
         head_q   <= head_d;
         en_q     <= en_d;
         isol_n_q <= isol_n_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         prog_q   <= prog_d;
      end
   end

   assign ccff_head     = head_q;
   assign chain_clk_en  = en_q;
   assign IO_ISOL_N     = isol_n_q;
   assign cfg.cfg_ready = ready_q;
   assign busy          = busy_q;
   assign done          = done_q;

`ifdef IO_CCFF_READBACK_EN
   logic        crc_clr;
   logic        rb_load;
   logic [15:0] crc_val;
   logic [15:0] rb_crc_q;

   // The tail bit leaving the chain in an enabled cycle is old content.
   assign crc_clr = (state_q == ST_IDLE) && start;
   assign rb_load = (state_q == ST_SHIFT) && (bitcnt_q == LAST_BIT);

   io_ccff_crc16 u_crc (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .clr_i    (crc_clr),
      .en_i     (en_q),
      .bit_i    (ccff_tail),
      .crc_o    (crc_val)
   );

   // Capture the finished CRC on entry to ISO_POST; held until the next pass.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n)    rb_crc_q <= '0;
      else if (rb_load) rb_crc_q <= crc_val;
   end

   assign rb_crc = rb_crc_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
   assign rb_crc      = '0;
`endif
endmodule

// File: tb/tb_io_ccff_loader.sv
// Scoreboard bench for io_ccff_loader: one 4-bit chain instance (with a chain
// model feeding ccff_tail) and one 12-bit chain instance for the stall case.
module tb_io_ccff_loader;
   localparam int WORD_W   = 8;
   localparam int ISO_HOLD = 4;
   localparam int LEN_A    = 4;
   localparam int LEN_B    = 12;
   localparam int FIRST_EN = 1 + ISO_HOLD + 2;

   logic prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   int cyc = 0;
   always @(posedge prog_clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] crc_ref(input logic [31:0] bits, input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // ---------------- DUT A: 4-bit chain ----------------
   logic rst_a_n, start_a, tail_a, head_a, en_a, isol_a, busy_a, done_a;
   logic [15:0] crc_a;
   io_ccff_loader_if #(.WORD_W(WORD_W)) if_a ();

   io_ccff_loader #(.CHAIN_LEN(LEN_A), .WORD_W(WORD_W), .ISO_HOLD(ISO_HOLD)) dut_a (
      .prog_clk(prog_clk), .pReset_n(rst_a_n), .start(start_a), .cfg(if_a),
      .ccff_tail(tail_a), .ccff_head(head_a), .chain_clk_en(en_a),
      .IO_ISOL_N(isol_a), .busy(busy_a), .done(done_a), .rb_crc(crc_a));

   logic [LEN_A-1:0] chain_a = '0;
   always @(posedge prog_clk) if (en_a) chain_a <= {chain_a[LEN_A-2:0], head_a};
   assign tail_a = chain_a[LEN_A-1];

   // ---------------- DUT B: 12-bit chain ----------------
   logic rst_b_n, start_b, tail_b, head_b, en_b, isol_b, busy_b, done_b;
   logic [15:0] crc_b;
   io_ccff_loader_if #(.WORD_W(WORD_W)) if_b ();
   assign tail_b = 1'b0;

   io_ccff_loader #(.CHAIN_LEN(LEN_B), .WORD_W(WORD_W), .ISO_HOLD(ISO_HOLD)) dut_b (
      .prog_clk(prog_clk), .pReset_n(rst_b_n), .start(start_b), .cfg(if_b),
      .ccff_tail(tail_b), .ccff_head(head_b), .chain_clk_en(en_b),
      .IO_ISOL_N(isol_b), .busy(busy_b), .done(done_b), .rb_crc(crc_b));

   // ---------------- scoreboard ----------------
   logic bit_q_a[$];
   logic bit_q_b[$];
   int   done_q_a[$];
   int   done_q_b[$];
   int   start_cyc_a = 0, start_cyc_b = 0;
   int   pass_en_a = 0, pass_en_b = 0;
   int   last_en_a = 0, last_en_b = 0;
   int   n_done_a = 0, n_done_b = 0;

   // Monitor A: every enable pops one expected bit; every done closes a pass.
   always @(negedge prog_clk) begin
      if (!rst_a_n) begin
         pass_en_a = 0;
      end else begin
         if (busy_a) check("a_isol_while_busy", isol_a, 0);
         if (en_a) begin
            if (pass_en_a == 0) check("a_first_en_latency", cyc - start_cyc_a, FIRST_EN);
            check("a_en_expected", bit_q_a.size() != 0, 1);
            if (bit_q_a.size() != 0) check("a_head_bit", head_a, bit_q_a.pop_front());
            pass_en_a++;
            last_en_a = cyc;
         end
         if (done_a) begin
            check("a_done_isol", isol_a, 1);
            check("a_done_busy", busy_a, 0);
            check("a_done_gap", cyc - last_en_a, ISO_HOLD + 1);
            check("a_en_count", pass_en_a, LEN_A);
            check("a_done_expected", done_q_a.size() != 0, 1);
            if (done_q_a.size() != 0) void'(done_q_a.pop_front());
`ifndef IO_CCFF_READBACK_EN
            check("a_rb_crc_tied", crc_a, 0);
`endif
            pass_en_a = 0;
            n_done_a++;
         end
      end
   end

   // Monitor B: same checks for the 12-bit chain.
   always @(negedge prog_clk) begin
      if (!rst_b_n) begin
         pass_en_b = 0;
      end else begin
         if (busy_b) check("b_isol_while_busy", isol_b, 0);
         if (en_b) begin
            if (pass_en_b == 0) check("b_first_en_latency", cyc - start_cyc_b, FIRST_EN);
            check("b_en_expected", bit_q_b.size() != 0, 1);
            if (bit_q_b.size() != 0) check("b_head_bit", head_b, bit_q_b.pop_front());
            pass_en_b++;
            last_en_b = cyc;
         end
         if (done_b) begin
            check("b_done_isol", isol_b, 1);
            check("b_done_gap", cyc - last_en_b, ISO_HOLD + 1);
            check("b_en_count", pass_en_b, LEN_B);
            check("b_done_expected", done_q_b.size() != 0, 1);
            if (done_q_b.size() != 0) void'(done_q_b.pop_front());
            pass_en_b = 0;
            n_done_b++;
         end
      end
   end

   // One full pass on DUT A with a single held word; optional start pulse mid-shift.
   task automatic run_pass_a(input logic [7:0] w, input bit pulse_mid);
      int d0;
      int n;
      for (int i = 0; i < LEN_A; i++) bit_q_a.push_back(w[i]);
      done_q_a.push_back(1);
      d0 = n_done_a;
      @(posedge prog_clk); #1;
      if_a.cfg_data  = w;
      if_a.cfg_valid = 1'b1;
      start_a        = 1'b1;
      start_cyc_a    = cyc;
      @(posedge prog_clk); #1;
      start_a = 1'b0;
      check("a_isol_after_start", isol_a, 0);
      check("a_busy_after_start", busy_a, 1);
      if (pulse_mid) begin
         n = 0;
         while (!en_a && n < 50) begin @(negedge prog_clk); #1; n++; end
         check("a_mid_reached_shift", en_a, 1);
         @(posedge prog_clk); #1; start_a = 1'b1;
         @(posedge prog_clk); #1; start_a = 1'b0;
      end
      n = 0;
      while (n_done_a == d0 && n < 100) begin @(negedge prog_clk); #1; n++; end
      check("a_done_seen", n_done_a - d0, 1);
      if_a.cfg_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int n;
      logic [7:0]  wb;
      logic [15:0] exp_crc;

      rst_a_n = 1'b1; rst_b_n = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      if_a.cfg_valid = 1'b0; if_a.cfg_data = '0;
      if_b.cfg_valid = 1'b0; if_b.cfg_data = '0;
      #1 rst_a_n = 1'b0; rst_b_n = 1'b0;
      #1;
      check("rst_a_head",  head_a, 0);
      check("rst_a_en",    en_a, 0);
      check("rst_a_isol",  isol_a, 0);
      check("rst_a_ready", if_a.cfg_ready, 0);
      check("rst_a_busy",  busy_a, 0);
      check("rst_a_done",  done_a, 0);
      check("rst_a_crc",   crc_a, 0);
      check("rst_b_en",    en_b, 0);
      check("rst_b_isol",  isol_b, 0);
      check("rst_b_busy",  busy_b, 0);
      @(posedge prog_clk); #1 rst_a_n = 1'b1; rst_b_n = 1'b1;
      repeat (2) @(posedge prog_clk);
      #1;

      // Pass 1: 0xA5 into 4-bit chain -> 1,0,1,0
      check("a_isol_unprogrammed", isol_a, 0);
      run_pass_a(8'hA5, 1'b0);

      // Pass 2: from programmed IDLE, start pulsed during SHIFT is ignored
      repeat (3) @(posedge prog_clk); #1;
      check("a_isol_programmed", isol_a, 1);
      d0 = n_done_a;
      run_pass_a(8'h5A, 1'b1);
      repeat (15) @(posedge prog_clk); #1;
      check("a_single_done", n_done_a - d0, 1);
      check("a_idle_after_pass", busy_a, 0);

      // Pass 3: reset after the 2nd shift
      wb = 8'hA5;
      for (int i = 0; i < LEN_A; i++) bit_q_a.push_back(wb[i]);
      @(posedge prog_clk); #1;
      if_a.cfg_data = wb; if_a.cfg_valid = 1'b1; start_a = 1'b1; start_cyc_a = cyc;
      @(posedge prog_clk); #1 start_a = 1'b0;
      n = 0;
      while (pass_en_a < 2 && n < 50) begin @(negedge prog_clk); #1; n++; end
      check("a_reached_2nd_shift", pass_en_a, 2);
      @(posedge prog_clk); #1 rst_a_n = 1'b0;
      #1;
      check("rst_mid_head",  head_a, 0);
      check("rst_mid_en",    en_a, 0);
      check("rst_mid_isol",  isol_a, 0);
      check("rst_mid_ready", if_a.cfg_ready, 0);
      check("rst_mid_busy",  busy_a, 0);
      check("rst_mid_done",  done_a, 0);
      bit_q_a.delete();
      if_a.cfg_valid = 1'b0;
      repeat (2) @(posedge prog_clk); #1 rst_a_n = 1'b1;
      repeat (2) @(posedge prog_clk); #1;
      check("a_isol_after_reset", isol_a, 0);

      // Pass 4: full pass after reset, loads 1,1,1,1
      run_pass_a(8'h0F, 1'b0);

      // Pass 5: loads 0; readback sees the previous 1,1,1,1
      run_pass_a(8'h00, 1'b0);
      exp_crc = crc_ref(32'hF, 4);
`ifndef IO_CCFF_READBACK_EN
      exp_crc = 16'h0;
`endif
      check("a_rb_crc", crc_a, exp_crc);

      // DUT B: 12-bit chain, 0x3C then 0x0F with a source stall between
      wb = 8'h3C;
      for (int i = 0; i < 8; i++) bit_q_b.push_back(wb[i]);
      wb = 8'h0F;
      for (int i = 0; i < 4; i++) bit_q_b.push_back(wb[i]);
      done_q_b.push_back(1);
      d0 = n_done_b;
      @(posedge prog_clk); #1;
      if_b.cfg_data = 8'h3C; if_b.cfg_valid = 1'b1; start_b = 1'b1; start_cyc_b = cyc;
      @(posedge prog_clk); #1 start_b = 1'b0;
      n = 0;
      while (!if_b.cfg_ready && n < 50) begin @(negedge prog_clk); #1; n++; end
      check("b_first_ready", if_b.cfg_ready, 1);
      @(posedge prog_clk); #1 if_b.cfg_valid = 1'b0;
      n = 0;
      do begin @(negedge prog_clk); #1; n++; end while (!if_b.cfg_ready && n < 50);
      check("b_refill_ready", if_b.cfg_ready, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge prog_clk); #1;
         check("b_stall_en", en_b, 0);
         check("b_stall_head_hold", head_b, 0);
         check("b_stall_ready", if_b.cfg_ready, 1);
      end
      if_b.cfg_data = 8'h0F; if_b.cfg_valid = 1'b1;
      n = 0;
      while (n_done_b == d0 && n < 100) begin @(negedge prog_clk); #1; n++; end
      check("b_done_seen", n_done_b - d0, 1);
      if_b.cfg_valid = 1'b0;

      repeat (3) @(posedge prog_clk); #1;
      check("a_bits_left", bit_q_a.size(), 0);
      check("b_bits_left", bit_q_b.size(), 0);
      check("a_dones_left", done_q_a.size(), 0);
      check("b_dones_left", done_q_b.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/io_ccff_loader.md
# io_ccff_loader

Programming sequencer for the IO-tile configuration chain. It accepts a configuration bitstream as a word stream and serialises it onto the IO tiles' `ccff_head` chain. It gates chain shifting through a clock-enable and holds `IO_ISOL_N` asserted (isolated) for the whole programming window. It sits above the IO grid tiles, one instance per chain, and is driven by the bitstream loader.

## Interface
- `CHAIN_LEN`, 4: total configuration bits in the chain, from head to tail; ≥1.
- `WORD_W`, 8: input word width.
- `ISO_HOLD`, 4: cycles isolation is held before the first shift and after the last shift; ≥1.
- `prog_clk`  in  1  programming clock; all state on its rising edge.
- `pReset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a programming pass; ignored unless in IDLE.
- `cfg_data`  in  WORD_W  bitstream word; LSB shifted first.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  word accepted on a cycle where `cfg_valid && cfg_ready`.
- `ccff_tail`  in  1  chain output; used only for readback.
- `ccff_head`  out  1  serial bit into the chain.
- `chain_clk_en`  out  1  enable for the external chain clock gate; the chain shifts on the `prog_clk` edge ending a cycle with this signal high.
- `IO_ISOL_N`  out  1  isolation control to the IO tiles; 0 means isolated.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a pass completes.
- `rb_crc`  out  16  CRC of the previous chain contents (see Configuration).

## Operation
- FSM states: IDLE → ISO_PRE → SHIFT → ISO_POST → IDLE.
- IDLE:
  - `IO_ISOL_N` is 1 after at least one completed pass, else 0.
  - `start` goes to ISO_PRE, drives `IO_ISOL_N`=0, and clears the bit counter.
- ISO_PRE: counts `ISO_HOLD` cycles, then enters SHIFT.
- SHIFT:
  - A WORD_W-bit shift buffer plus a valid-bit count (0..WORD_W).
  - `cfg_ready`=1 only when the buffer is empty and bits remain to be sent.
  - An accepted word loads the buffer.
  - Each cycle with buffer non-empty: `ccff_head` is set to buffer[0] and `chain_clk_en` is set to 1 for that cycle; the buffer shifts right; the bit counter increments.
  - Buffer empty (source stalled): `chain_clk_en`=0 and `ccff_head` holds its value. Stalls of any length are legal.
  - When the bit counter reaches `CHAIN_LEN`, the FSM goes to ISO_POST. Bits left in the final word are discarded and the buffer is cleared.
- ISO_POST:
  - Counts `ISO_HOLD` cycles with `chain_clk_en`=0.
  - Then sets `IO_ISOL_N`=1, pulses `done`, sets the sticky "programmed" flag, and returns to IDLE.
- Bit counter width is clog2(CHAIN_LEN+1). It never wraps, and exactly `CHAIN_LEN` enables are issued per pass.
- `start` while busy is ignored. A new pass from IDLE re-isolates (`IO_ISOL_N`=0) before any shift.
- Reset mid-pass:
  - All state returns to IDLE immediately and the programmed flag clears.
  - `IO_ISOL_N`=0 and `chain_clk_en`=0, so the chain contents are undefined until the next full pass.

## Timing
- Reset values: `ccff_head`=0, `chain_clk_en`=0, `IO_ISOL_N`=0, `cfg_ready`=0, `busy`=0, `done`=0, `rb_crc`=0.
- All outputs are registered. `ccff_head` and `chain_clk_en` update on the same edge.
- `start` to first `chain_clk_en`: 1 (ISO_PRE entry) + `ISO_HOLD` + 1 (word accept) + 1 cycles, given `cfg_valid` already high.
- Peak throughput: WORD_W bits per WORD_W+1 cycles (one cycle for the buffer refill).
- Last shift to `IO_ISOL_N`=1: `ISO_HOLD`+1 cycles; `done` is asserted in that same cycle.

## Configuration
- `IO_CCFF_READBACK_EN` defined:
  - During SHIFT, on each enabled cycle, `ccff_tail` (the previous contents, oldest bit first) is folded into CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first update).
  - `rb_crc` is loaded with the final value when the FSM enters ISO_POST and holds it until the next pass ends.
- Not defined: no CRC logic, `rb_crc` is tied to 0, and `ccff_tail` is unused.

## Structure
- Shared package `io_ccff_pkg`: FSM state enum, CRC polynomial/init constants, a `clog2`-based counter-width helper.
- One sub-module: `io_ccff_crc16` (serial CRC update: enable, bit in, value). Instantiated only under the macro.

## Test plan
- CHAIN_LEN=4, WORD_W=8, ISO_HOLD=4, word 0xA5, `cfg_valid` held → `ccff_head` sequence 1,0,1,0 with 4 consecutive enables; upper nibble dropped; `IO_ISOL_N` rises 5 cycles after the last enable, together with `done`.
- CHAIN_LEN=12, words 0x3C then 0x0F, `cfg_valid` dropped for 5 cycles between the words → exactly 12 enables; `chain_clk_en`=0 throughout the stall; bits 0,0,1,1,1,1,0,0,1,1,1,1.
- `start` pulsed during SHIFT → ignored: enable count unchanged and a single `done`.
- `pReset_n` low after the 2nd shift → all outputs reach reset values immediately; next `start` gives a full 4-bit pass with `IO_ISOL_N`=0 until it ends.
- Readback build, first pass loads 0xF into a 4-bit chain, second pass loads 0x0 → `rb_crc` after the second pass equals the CRC of 1,1,1,1 (reference model).
- Second pass from a programmed IDLE → `IO_ISOL_N` falls to 0 the cycle after `start`, before any enable.
